// File: rtl/gate_chk_pkg.sv
// Shared types and defaults for the gate truth-table checker.
package gate_chk_pkg;

  localparam int unsigned GATE_CHK_NUM_IN_DEF   = 3;
  localparam int unsigned GATE_CHK_SETTLE_DEF   = 2;
  // Settle counter width covers the full 0..15 hold range.
  localparam int unsigned GATE_CHK_SETTLE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } gate_chk_state_e;

endpackage : gate_chk_pkg

// File: rtl/gate_chk_settle_timer.sv
// Per-vector hold counter: strobes sample_c on the last cycle a vector is held.
module gate_chk_settle_timer
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = GATE_CHK_SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sample_c
);

  logic [GATE_CHK_SETTLE_W-1:0] cnt_q;
  logic [GATE_CHK_SETTLE_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter restarts after every strobe so the next vector gets a full hold.
  always_comb begin
    sample_c = en_i && (cnt_q == GATE_CHK_SETTLE_W'(SETTLE_CYCLES));
    cnt_d    = cnt_q;
    if (!en_i || sample_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + GATE_CHK_SETTLE_W'(1);
    end
  end

endmodule : gate_chk_settle_timer

// File: rtl/gate_truth_checker.sv
// Sweeps all input vectors through an AND gate under test and scores its output.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned NUM_IN        = GATE_CHK_NUM_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = GATE_CHK_SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic [NUM_IN-1:0] drv_vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   err_cnt,
  output logic              fail_valid,
  output logic [NUM_IN-1:0] first_fail_vec
);

  localparam int unsigned ERR_W = NUM_IN + 1;

  gate_chk_state_e   state_q, state_d;
  logic [NUM_IN-1:0] idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;
  logic              fail_valid_q, fail_valid_d;
  logic [NUM_IN-1:0] first_fail_q, first_fail_d;

  logic drive_c;
  logic sample_c;
  logic expect_c;
  logic mismatch_c;
  logic last_c;
  logic stop_c;
  logic finish_c;

  assign drive_c    = (state_q == ST_DRIVE);
  assign expect_c   = &idx_q;
  assign last_c     = &idx_q;
  assign mismatch_c = sample_c && (dut_out != expect_c);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign stop_c = mismatch_c;
`else
  assign stop_c = 1'b0;
`endif

  assign finish_c = drive_c && sample_c && (last_c || stop_c);

  gate_chk_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (drive_c),
    .sample_c (sample_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: if (finish_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    drv_vec = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_DRIVE: begin
        drv_vec = idx_q;
        busy    = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Sweep datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      idx_q        <= idx_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Results are cleared on an accepted start and otherwise held between sweeps.
  always_comb begin
    idx_d        = idx_q;
    err_d        = err_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    if ((state_q == ST_IDLE) && start) begin
      idx_d        = '0;
      err_d        = '0;
      pass_d       = 1'b0;
      fail_valid_d = 1'b0;
      first_fail_d = '0;
    end else if (drive_c && sample_c) begin
      if (mismatch_c) begin
        err_d = err_q + ERR_W'(1);
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          first_fail_d = idx_q;
        end
      end
      if (finish_c) begin
        pass_d = (err_d == '0);
      end else begin
        idx_d = idx_q + NUM_IN'(1);
      end
    end
  end

  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule : gate_truth_checker

// File: tb/tb_gate_truth_checker.sv
// Directed, table-driven bench for gate_truth_checker (NUM_IN=3, SETTLE_CYCLES=2).
module tb_gate_truth_checker;

  localparam int NUM_IN  = 3;
  localparam int SETTLE  = 2;
  localparam int HOLD    = SETTLE + 1;
  localparam int BUDGET  = 200;

  logic              clk;
  logic              rst;
  logic              start;
  logic              dut_out;
  logic [NUM_IN-1:0] drv_vec;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NUM_IN:0]   err_cnt;
  logic              fail_valid;
  logic [NUM_IN-1:0] first_fail_vec;

  int gmode;  // 0 = correct AND, 1 = stuck at 0, 2 = stuck at 1
  int n_checks;
  int n_errors;

  gate_truth_checker #(
    .NUM_IN        (NUM_IN),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dut_out        (dut_out),
    .drv_vec        (drv_vec),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .fail_valid     (fail_valid),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (gmode)
      1:       dut_out = 1'b0;
      2:       dut_out = 1'b1;
      default: dut_out = &drv_vec;
    endcase
  end

  typedef struct {
    string    name;
    int       mode;
    bit       repulse;
    int       exp_busy;
    int       exp_err;
    bit       exp_fv;
    int       exp_ffv;
    bit       exp_pass;
  } sweep_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drv_vec"}, int'(drv_vec), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_fail_valid"}, int'(fail_valid), 0);
    check({tag, "_first_fail_vec"}, int'(first_fail_vec), 0);
  endtask

  // Runs one sweep from IDLE; checks the drive sequence, DONE cycle and held results.
  task automatic run_sweep(input sweep_vec_t v);
    int cycles;
    int drv_bad;
    gmode = v.mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles  = 0;
    drv_bad = 0;
    while (busy && cycles < BUDGET) begin
      if (int'(drv_vec) != cycles / HOLD) drv_bad++;
      start = (v.repulse && (cycles == 5 || cycles == 17)) ? 1'b1 : 1'b0;
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check({v.name, "_busy_cycles"}, cycles, v.exp_busy);
    check({v.name, "_drv_seq_bad"}, drv_bad, 0);
    check({v.name, "_done"}, int'(done), 1);
    check({v.name, "_pass"}, int'(pass), int'(v.exp_pass));
    check({v.name, "_err_cnt"}, int'(err_cnt), v.exp_err);
    check({v.name, "_fail_valid"}, int'(fail_valid), int'(v.exp_fv));
    check({v.name, "_first_fail_vec"}, int'(first_fail_vec), v.exp_ffv);
    check({v.name, "_drv_in_done"}, int'(drv_vec), 0);
    repeat (3) @(negedge clk);
    check({v.name, "_done_one_cycle"}, int'(done), 0);
    check({v.name, "_idle_busy"}, int'(busy), 0);
    check({v.name, "_hold_pass"}, int'(pass), int'(v.exp_pass));
    check({v.name, "_hold_err_cnt"}, int'(err_cnt), v.exp_err);
    check({v.name, "_hold_ffv"}, int'(first_fail_vec), v.exp_ffv);
  endtask

  sweep_vec_t tbl[5];

  initial begin
    int idle_busy;
    n_checks = 0;
    n_errors = 0;
    gmode    = 0;
    start    = 1'b0;

    tbl[0] = '{"and_ok",     0, 1'b0, 24, 0, 1'b0, 0, 1'b1};
    tbl[1] = '{"stuck0",     1, 1'b0, 24, 1, 1'b1, 7, 1'b0};
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    tbl[2] = '{"stuck1",     2, 1'b0,  3, 1, 1'b1, 0, 1'b0};
`else
    tbl[2] = '{"stuck1",     2, 1'b0, 24, 7, 1'b1, 0, 1'b0};
`endif
    tbl[3] = '{"restart",    0, 1'b1, 24, 0, 1'b0, 0, 1'b1};
    tbl[4] = '{"and_ok_2",   0, 1'b0, 24, 0, 1'b0, 0, 1'b1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i]);
    end

    // Mid-sweep reset with stale failure results present beforehand.
    run_sweep(tbl[1]);
    gmode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
`ifndef GATE_CHK_STOP_ON_FAIL_EN
    check("midrst_pre_busy", int'(busy), 1);
    check("midrst_pre_drv_vec", int'(drv_vec), 3);
`endif
    rst = 1'b1;
    #1;
    check_all_zero("midrst_async");
    @(negedge clk);
    check_all_zero("midrst_held");
    rst = 1'b0;
    idle_busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    check("midrst_no_autostart", idle_busy, 0);
    run_sweep(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gate_truth_checker
